// File: rtl/event_trigger_if.sv
// Sample, control and status bundle between the event trigger and its host/accumulator side.
// The trigger itself takes the slave view; whoever drives samples and controls takes master.
interface event_trigger_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic signed [7:0]      data_in;
  logic                   arm;
  logic                   force_trig;
  logic                   edge_sel;
  logic signed [7:0]      threshold;
  logic signed [7:0]      data_out;
  logic                   capture_strobe;
  logic                   busy;
  logic                   ready;
  logic [COUNT_WIDTH-1:0] trig_count;
  logic [7:0]             missed_count;

  modport master (
    output data_in, arm, force_trig, edge_sel, threshold,
    input  data_out, capture_strobe, busy, ready, trig_count, missed_count
  );

  modport slave (
    input  data_in, arm, force_trig, edge_sel, threshold,
    output data_out, capture_strobe, busy, ready, trig_count, missed_count
  );
endinterface

// File: rtl/event_trigger.sv
// Threshold-crossing trigger with hold-off for the ADC front end; also provides a fixed
// pre-trigger delay of the sample stream so captured records include samples before the event.
module event_trigger #(
  parameter int unsigned PRE_TRIG_DEPTH = 16,
  parameter int unsigned HOLDOFF_CYCLES = 132,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input logic           clk,
  input logic           rst,
  event_trigger_if.slave bus
);

  localparam int unsigned FillWidth = $clog2(PRE_TRIG_DEPTH + 1);
  localparam int unsigned HoldWidth = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [FillWidth-1:0] FillMax  = FillWidth'(PRE_TRIG_DEPTH);
  localparam logic [HoldWidth-1:0] HoldLoad = HoldWidth'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StHoldoff} state_e;

  logic signed [7:0]      stage_q [PRE_TRIG_DEPTH];
  logic [FillWidth-1:0]   fill_q;
  logic                   force_q;
  state_e                 state_q;
  logic [HoldWidth-1:0]   hold_q;
  logic                   strobe_q;
  logic [COUNT_WIDTH-1:0] trig_q;
  logic [7:0]             missed_q;

  logic              filled;
  logic signed [7:0] cur;
  logic signed [7:0] prev;
  logic              rise;
  logic              fall;
  logic              crossing;

  // Delay line shifts in every state so data_out is always a fixed-latency copy of data_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(PRE_TRIG_DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= bus.data_in;
      for (int i = 1; i < int'(PRE_TRIG_DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
    end else if (fill_q != FillMax) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  // force_trig is registered so it lines up with a crossing sampled into stage0 on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      force_q <= 1'b0;
    end else begin
      force_q <= bus.force_trig;
    end
  end

  always_comb begin
    filled   = (fill_q == FillMax);
    cur      = stage_q[0];
    prev     = stage_q[1];
    rise     = (prev < bus.threshold) && (cur >= bus.threshold);
    fall     = (prev >= bus.threshold) && (cur < bus.threshold);
    crossing = filled && (bus.edge_sel ? fall : rise);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      strobe_q <= 1'b0;
      trig_q   <= '0;
      missed_q <= '0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.arm && filled) begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (!bus.arm) begin
            state_q <= StIdle;
          end else if (crossing || force_q) begin
            strobe_q <= 1'b1;
            trig_q   <= trig_q + 1'b1;
            hold_q   <= HoldLoad;
            state_q  <= StHoldoff;
          end
        end
        StHoldoff: begin
          if (crossing && (missed_q != 8'hFF)) begin
            missed_q <= missed_q + 1'b1;
          end
          // Hold-off always runs to completion; arm only chooses where we land afterwards.
          if (hold_q == '0) begin
            state_q <= bus.arm ? StArmed : StIdle;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_out       = stage_q[PRE_TRIG_DEPTH-1];
  assign bus.capture_strobe = strobe_q;
  assign bus.busy           = (state_q == StHoldoff);
  assign bus.ready          = (state_q == StArmed);
  assign bus.trig_count     = trig_q;
  assign bus.missed_count   = missed_q;

endmodule

// File: tb/tb_event_trigger.sv
// Directed bench for event_trigger: ramp, square wave with hold-off, falling edge, forced
// triggers, reset during hold-off, missed-count saturation and trig_count wrap.
module tb_event_trigger;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  event_trigger_if #(.COUNT_WIDTH(16)) bus1 ();
  event_trigger_if #(.COUNT_WIDTH(8))  bus2 ();

  event_trigger #(
    .PRE_TRIG_DEPTH(16),
    .HOLDOFF_CYCLES(132),
    .COUNT_WIDTH   (16)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  // Short hold-off and narrow counter so the wrap is reachable quickly.
  event_trigger #(
    .PRE_TRIG_DEPTH(16),
    .HOLDOFF_CYCLES(1),
    .COUNT_WIDTH   (8)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus1.busy && n < 300) begin
      tick();
      n++;
    end
    chk("holdoff_exit", 32'(bus1.busy), 0);
  endtask

  function automatic logic signed [7:0] sq(input int p);
    return ((p % 40) < 20) ? -8'sd50 : 8'sd50;
  endfunction

  initial begin
    bus1.data_in    = -8'sd20;
    bus1.arm        = 1'b1;
    bus1.force_trig = 1'b0;
    bus1.edge_sel   = 1'b0;
    bus1.threshold  = 8'sd10;
    bus2.data_in    = 8'sd0;
    bus2.arm        = 1'b1;
    bus2.force_trig = 1'b0;
    bus2.edge_sel   = 1'b0;
    bus2.threshold  = 8'sd0;

    // Reset state
    tick();
    tick();
    chk("rst_data_out", 32'(bus1.data_out), 0);
    chk("rst_strobe", 32'(bus1.capture_strobe), 0);
    chk("rst_busy", 32'(bus1.busy), 0);
    chk("rst_ready", 32'(bus1.ready), 0);
    chk("rst_trig", 32'(bus1.trig_count), 0);
    chk("rst_missed", 32'(bus1.missed_count), 0);
    #2 rst = 1'b0;

    // Ramp -20..+20 captured at edges 1..41; 10 lands in stage0 at edge 31
    for (int e = 1; e <= 50; e++) begin
      tick();
      bus1.data_in = (e + 1 <= 41) ? 8'(-21 + e + 1) : 8'sd20;
      chk("ramp_strobe", 32'(bus1.capture_strobe), 32'(e == 32));
      if (e == 16) chk("ramp_ready_early", 32'(bus1.ready), 0);
      if (e == 17) chk("ramp_ready", 32'(bus1.ready), 1);
      if (e == 32) chk("ramp_trig", 32'(bus1.trig_count), 1);
      if (e == 32) chk("ramp_busy", 32'(bus1.busy), 1);
      if (e == 46) chk("ramp_data_out", 32'(bus1.data_out), 10);
    end

    // Square wave -50/+50, period 40, threshold 0
    wait_idle();
    bus1.arm = 1'b0;
    tick();
    bus1.threshold = 8'sd0;
    bus1.arm = 1'b1;
    tick();
    for (int p = 0; p <= 345; p++) begin
      bus1.data_in = sq(p);
      tick();
      chk("sq_strobe", 32'(bus1.capture_strobe), 32'(p == 21 || p == 181 || p == 341));
      if (p == 21)  chk("sq_missed0", 32'(bus1.missed_count), 0);
      if (p == 181) chk("sq_missed3", 32'(bus1.missed_count), 3);
      if (p == 341) chk("sq_missed6", 32'(bus1.missed_count), 6);
      if (p == 152 || p == 312) chk("sq_busy_last", 32'(bus1.busy), 1);
      if (p == 153 || p == 313) chk("sq_busy_end", 32'(bus1.busy), 0);
      if (p == 153) chk("sq_ready", 32'(bus1.ready), 1);
    end
    chk("sq_trig", 32'(bus1.trig_count), 4);

    // Falling edge, threshold -5
    wait_idle();
    bus1.arm = 1'b0;
    bus1.data_in = 8'sd0;
    tick();
    bus1.edge_sel = 1'b1;
    bus1.threshold = -8'sd5;
    bus1.arm = 1'b1;
    tick();
    chk("fall_ready", 32'(bus1.ready), 1);
    bus1.data_in = -8'sd5;
    tick();
    tick();
    chk("fall_equal_no_strobe", 32'(bus1.capture_strobe), 0);
    chk("fall_equal_trig", 32'(bus1.trig_count), 4);
    bus1.data_in = -8'sd6;
    tick();
    chk("fall_latency", 32'(bus1.capture_strobe), 0);
    tick();
    chk("fall_strobe", 32'(bus1.capture_strobe), 1);
    chk("fall_trig", 32'(bus1.trig_count), 5);
    wait_idle();
    chk("fall_rearm", 32'(bus1.ready), 1);
    bus1.data_in = -8'sd5;
    tick();
    tick();
    chk("rise_ignored", 32'(bus1.capture_strobe), 0);
    tick();
    chk("rise_ignored2", 32'(bus1.capture_strobe), 0);
    chk("rise_trig", 32'(bus1.trig_count), 5);

    // Crossing and force on the same edge
    bus1.data_in = -8'sd10;
    bus1.force_trig = 1'b1;
    tick();
    bus1.force_trig = 1'b0;
    chk("both_latency", 32'(bus1.capture_strobe), 0);
    tick();
    chk("both_strobe", 32'(bus1.capture_strobe), 1);
    chk("both_trig", 32'(bus1.trig_count), 6);
    tick();
    chk("both_one_cycle", 32'(bus1.capture_strobe), 0);
    // Force during hold-off
    bus1.force_trig = 1'b1;
    tick();
    bus1.force_trig = 1'b0;
    tick();
    chk("hold_force1", 32'(bus1.capture_strobe), 0);
    tick();
    chk("hold_force2", 32'(bus1.capture_strobe), 0);
    chk("hold_force_trig", 32'(bus1.trig_count), 6);
    // Force in idle
    wait_idle();
    bus1.arm = 1'b0;
    tick();
    chk("idle_ready", 32'(bus1.ready), 0);
    bus1.force_trig = 1'b1;
    tick();
    bus1.force_trig = 1'b0;
    tick();
    chk("idle_force1", 32'(bus1.capture_strobe), 0);
    tick();
    chk("idle_force2", 32'(bus1.capture_strobe), 0);
    chk("idle_force_trig", 32'(bus1.trig_count), 6);
    // Force alone while armed
    bus1.arm = 1'b1;
    tick();
    bus1.force_trig = 1'b1;
    tick();
    bus1.force_trig = 1'b0;
    chk("force_latency", 32'(bus1.capture_strobe), 0);
    tick();
    chk("force_strobe", 32'(bus1.capture_strobe), 1);
    chk("force_trig", 32'(bus1.trig_count), 7);

    // Reset with hold-off counter at 60
    repeat (71) tick();
    chk("pre_rst_busy", 32'(bus1.busy), 1);
    chk("pre_rst_missed", 32'(bus1.missed_count), 6);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus1.busy), 0);
    chk("arst_trig", 32'(bus1.trig_count), 0);
    chk("arst_missed", 32'(bus1.missed_count), 0);
    chk("arst_data_out", 32'(bus1.data_out), 0);
    chk("arst_ready", 32'(bus1.ready), 0);
    bus1.data_in = 8'sd0;
    #1 rst = 1'b0;

    // Falling crossing every other edge: refill, then saturate missed_count
    for (int e = 1; e <= 560; e++) begin
      tick();
      bus1.data_in = ((e + 1) % 2 == 0) ? -8'sd10 : 8'sd0;
      if (e <= 20) chk("refill_strobe", 32'(bus1.capture_strobe), 32'(e == 19));
      if (e == 16) chk("refill_ready_early", 32'(bus1.ready), 0);
      if (e == 17) chk("refill_ready", 32'(bus1.ready), 1);
      if (e == 19) chk("refill_trig", 32'(bus1.trig_count), 1);
      if (e == 151) chk("missed_66", 32'(bus1.missed_count), 66);
      if (e == 153) chk("second_strobe", 32'(bus1.capture_strobe), 1);
    end
    chk("missed_sat", 32'(bus1.missed_count), 255);
    chk("sat_trig", 32'(bus1.trig_count), 5);

    // trig_count wrap on the narrow instance
    chk("wrap_ready", 32'(bus2.ready), 1);
    chk("wrap_start", 32'(bus2.trig_count), 0);
    for (int i = 0; i < 256; i++) begin
      bus2.force_trig = 1'b1;
      tick();
      bus2.force_trig = 1'b0;
      tick();
      chk("wrap_strobe", 32'(bus2.capture_strobe), 1);
      chk("wrap_count", 32'(bus2.trig_count), 32'((i + 1) % 256));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
